// File: rtl/romulus_config_pkg.sv
// Shared configuration for the Romulus datapath: tweakey state encoding and defaults.
package romulus_config_pkg;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam int unsigned DEFAULT_RCW = 6;

  typedef enum logic [1:0] {
    StEmpty   = ST_EMPTY,
    StLoading = ST_LOADING,
    StFull    = ST_FULL,
    StRun     = ST_RUN
  } tk_state_e;

endpackage

// File: rtl/tk_load_ctrl.sv
// Tweakey load controller: state machine, beat counter, TBC round counter and sticky error.
module tk_load_ctrl
  import romulus_config_pkg::*;
#(
  parameter int unsigned BEATS     = 4,
  parameter int unsigned RCW       = DEFAULT_RCW,
  parameter bit          RELOAD_EN = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           ld_valid,
  input  logic           upd_en,
  input  logic           upd_tbc,
  output logic           ld_ready,
  output logic           accept,
  output logic           upd_apply,
  output logic           loaded,
  output logic           busy,
  output logic [RCW-1:0] rnd_cnt,
  output logic           err
);

  localparam int unsigned     CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]   LAST = CW'(BEATS - 1);

  tk_state_e      r_state, w_state_d;
  logic [CW-1:0]  r_beat, w_beat_d;
  logic [RCW-1:0] r_rnd, w_rnd_d;
  logic           r_err, w_err_d;
  logic           w_held;

  assign w_held    = (r_state == StFull) || (r_state == StRun);
  assign ld_ready  = (r_state == StEmpty) || (r_state == StLoading) || (RELOAD_EN && w_held);
  assign accept    = ld_valid & ld_ready;
  assign upd_apply = upd_en & w_held & ~accept & ~clr;

  // The beat counter is always 0 in FULL/RUN, so a reload beat falls into the normal path.
  always_comb begin
    w_state_d = r_state;
    w_beat_d  = r_beat;
    w_rnd_d   = r_rnd;
    w_err_d   = r_err;
    if (clr) begin
      w_state_d = StEmpty;
      w_beat_d  = '0;
      w_rnd_d   = '0;
      w_err_d   = 1'b0;
    end else if (accept) begin
      w_rnd_d = '0;
      if (upd_en) begin
        w_err_d = 1'b1;
      end
      if (r_beat == LAST) begin
        w_state_d = StFull;
        w_beat_d  = '0;
      end else begin
        w_state_d = StLoading;
        w_beat_d  = r_beat + 1'b1;
      end
    end else if (upd_en) begin
      if (w_held) begin
        w_state_d = StRun;
        w_rnd_d   = upd_tbc ? r_rnd + 1'b1 : '0;
      end else begin
        w_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
      r_beat  <= '0;
      r_rnd   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_beat  <= w_beat_d;
      r_rnd   <= w_rnd_d;
      r_err   <= w_err_d;
    end
  end

  assign loaded  = w_held;
  assign busy    = (r_state == StLoading);
  assign rnd_cnt = r_rnd;
  assign err     = r_err;

endmodule

// File: rtl/romulus_tkey_loader.sv
// Multi-share tweakey register: beat-wise shift load, per-round/correction update, control FSM.
module romulus_tkey_loader
  import romulus_config_pkg::*;
#(
  parameter int unsigned BUSW      = 32,
  parameter int unsigned SHARES    = 1,
  parameter int unsigned RCW       = DEFAULT_RCW,
  parameter bit          RELOAD_EN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [BUSW-1:0]       ld_data,
  input  logic                  upd_en,
  input  logic                  upd_tbc,
  input  logic [128*SHARES-1:0] tkx_tbc_i,
  input  logic [128*SHARES-1:0] tkx_correct_i,
  output logic [128*SHARES-1:0] tkx_o,
  output logic                  loaded,
  output logic                  busy,
  output logic [RCW-1:0]        rnd_cnt,
  output logic                  err
);

  localparam int unsigned TKW   = 128 * SHARES;
  localparam int unsigned BEATS = TKW / BUSW;

  logic [TKW-1:0] r_tkx;
  logic [TKW-1:0] w_shift;
  logic           w_accept;
  logic           w_upd;

  tk_load_ctrl #(
    .BEATS     (BEATS),
    .RCW       (RCW),
    .RELOAD_EN (RELOAD_EN)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .ld_valid  (ld_valid),
    .upd_en    (upd_en),
    .upd_tbc   (upd_tbc),
    .ld_ready  (ld_ready),
    .accept    (w_accept),
    .upd_apply (w_upd),
    .loaded    (loaded),
    .busy      (busy),
    .rnd_cnt   (rnd_cnt),
    .err       (err)
  );

  // First beat shifts up into the MSBs as later beats arrive.
  if (BEATS == 1) begin : g_single
    assign w_shift = ld_data;
  end else begin : g_multi
    assign w_shift = {r_tkx[TKW-BUSW-1:0], ld_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tkx <= '0;
    end else if (clr) begin
      r_tkx <= '0;
    end else if (w_accept) begin
      r_tkx <= w_shift;
    end else if (w_upd) begin
      r_tkx <= upd_tbc ? tkx_tbc_i : tkx_correct_i;
    end
  end

  assign tkx_o = r_tkx;

endmodule

// File: tb/tb_romulus_tkey_loader.sv
// Scoreboard bench: stimulus queues expected per-cycle snapshots, a negedge monitor compares them.
module tb_romulus_tkey_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   clr, vld, upd;
  logic         upd_tbc;
  logic [127:0] ld_data;
  logic [255:0] tbc, cor;
  logic [2:0]   rdy, ldd, bsy, er;
  logic [5:0]   rnd0, rnd1, rnd2;
  logic [127:0] tkx0, tkx1;
  logic [255:0] tkx2;

  // dut 0: default, no reload; dut 1: reload enabled; dut 2: wide bus, two shares
  romulus_tkey_loader #(.BUSW(32), .SHARES(1), .RCW(6), .RELOAD_EN(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .ld_valid(vld[0]), .ld_ready(rdy[0]),
    .ld_data(ld_data[31:0]), .upd_en(upd[0]), .upd_tbc(upd_tbc), .tkx_tbc_i(tbc[127:0]),
    .tkx_correct_i(cor[127:0]), .tkx_o(tkx0), .loaded(ldd[0]), .busy(bsy[0]),
    .rnd_cnt(rnd0), .err(er[0])
  );

  romulus_tkey_loader #(.BUSW(32), .SHARES(1), .RCW(6), .RELOAD_EN(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .ld_valid(vld[1]), .ld_ready(rdy[1]),
    .ld_data(ld_data[31:0]), .upd_en(upd[1]), .upd_tbc(upd_tbc), .tkx_tbc_i(tbc[127:0]),
    .tkx_correct_i(cor[127:0]), .tkx_o(tkx1), .loaded(ldd[1]), .busy(bsy[1]),
    .rnd_cnt(rnd1), .err(er[1])
  );

  romulus_tkey_loader #(.BUSW(128), .SHARES(2), .RCW(6), .RELOAD_EN(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .ld_valid(vld[2]), .ld_ready(rdy[2]),
    .ld_data(ld_data), .upd_en(upd[2]), .upd_tbc(upd_tbc), .tkx_tbc_i(tbc),
    .tkx_correct_i(cor), .tkx_o(tkx2), .loaded(ldd[2]), .busy(bsy[2]),
    .rnd_cnt(rnd2), .err(er[2])
  );

  typedef struct {
    int           cyc;
    int           dut;
    string        nm;
    logic [255:0] tkx;
    logic         ld;
    logic         bz;
    logic         rdy;
    logic         er;
    logic [5:0]   rnd;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input int d, input string nm, input logic [255:0] t,
                           input logic ld, input logic bz, input logic rd, input logic e,
                           input int rnd);
    exp_t x;
    x.cyc = c; x.dut = d; x.nm = nm; x.tkx = t;
    x.ld = ld; x.bz = bz; x.rdy = rd; x.er = e; x.rnd = rnd[5:0];
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int d, input logic [127:0] data);
    tick();
    clr = '0; upd = '0; vld = '0;
    vld[d] = 1'b1;
    ld_data = data;
  endtask

  localparam logic [127:0] FULL = 128'h00112233445566778899AABBCCDDEEFF;
  logic [31:0]  beats32 [4];
  logic [127:0] part    [4];

  task automatic load4(input int d, input logic reload);
    for (int i = 0; i < 4; i++) begin
      drive_beat(d, {96'h0, beats32[i]});
      expect_at(cyc + 1, d, $sformatf("load4 beat%0d", i + 1), part[i], i == 3, i != 3,
                (i != 3) || reload, 1'b0, 0);
    end
  endtask

  // Monitor
  initial begin
    exp_t         e;
    logic [255:0] a_t;
    logic         a_ld, a_bz, a_rd, a_er;
    logic [5:0]   a_rnd;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s: check missed at cycle %0d, required cycle %0d", e.nm, cyc, e.cyc);
        end else begin
          case (e.dut)
            0: begin
              a_t = {128'h0, tkx0}; a_ld = ldd[0]; a_bz = bsy[0]; a_rd = rdy[0];
              a_er = er[0]; a_rnd = rnd0;
            end
            1: begin
              a_t = {128'h0, tkx1}; a_ld = ldd[1]; a_bz = bsy[1]; a_rd = rdy[1];
              a_er = er[1]; a_rnd = rnd1;
            end
            default: begin
              a_t = tkx2; a_ld = ldd[2]; a_bz = bsy[2]; a_rd = rdy[2];
              a_er = er[2]; a_rnd = rnd2;
            end
          endcase
          if ({a_t, a_ld, a_bz, a_rd, a_er, a_rnd} !==
              {e.tkx, e.ld, e.bz, e.rdy, e.er, e.rnd}) begin
            errors++;
            $display({"FAIL %s (dut%0d): got tkx=%h loaded=%b busy=%b ld_ready=%b err=%b ",
                      "rnd=%0d; required tkx=%h loaded=%b busy=%b ld_ready=%b err=%b rnd=%0d"},
                     e.nm, e.dut, a_t, a_ld, a_bz, a_rd, a_er, a_rnd,
                     e.tkx, e.ld, e.bz, e.rdy, e.er, e.rnd);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int waited;
    beats32 = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    part    = '{128'h00112233, 128'h0011223344556677, 128'h00112233445566778899AABB, FULL};
    rst_n = 1'b0; clr = '0; vld = '0; upd = '0; upd_tbc = 1'b0;
    ld_data = '0; tbc = '0; cor = '0;
    repeat (3) @(posedge clk);
    tick();
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) expect_at(cyc, d, "reset state", '0, 0, 0, 1, 0, 0);

    // Basic 4-beat load, then ld_valid while not ready is ignored
    load4(0, 1'b0);
    drive_beat(0, 128'hDEADBEEF);
    expect_at(cyc + 1, 0, "valid while not ready", FULL, 1, 0, 0, 0, 0);

    // Three TBC rounds then one correction
    for (int i = 1; i <= 3; i++) begin
      tick();
      vld = '0; upd[0] = 1'b1; upd_tbc = 1'b1; tbc = 256'(i);
      expect_at(cyc + 1, 0, $sformatf("tbc update %0d", i), 256'(i), 1, 0, 0, 0, i);
    end
    tick();
    upd_tbc = 1'b0; cor = {128'h0, {16{8'hAA}}};
    expect_at(cyc + 1, 0, "correction update", {16{8'hAA}}, 1, 0, 0, 0, 0);

    // Update during LOADING is an error; clr wipes it
    tick();
    upd = '0; clr[0] = 1'b1;
    expect_at(cyc + 1, 0, "clr after run", '0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive_beat(0, {96'h0, beats32[i]});
      expect_at(cyc + 1, 0, $sformatf("partial beat%0d", i + 1), part[i], 0, 1, 1, 0, 0);
    end
    tick();
    vld = '0; upd[0] = 1'b1; upd_tbc = 1'b1; tbc = 256'h99;
    expect_at(cyc + 1, 0, "update while loading", part[1], 0, 1, 1, 1, 0);
    tick();
    upd = '0;
    expect_at(cyc + 1, 0, "err sticky", part[1], 0, 1, 1, 1, 0);
    tick();
    clr[0] = 1'b1;
    expect_at(cyc + 1, 0, "clr clears err", '0, 0, 0, 1, 0, 0);

    // Asynchronous reset in the middle of a load
    for (int i = 0; i < 2; i++) begin
      drive_beat(0, {96'h0, beats32[i]});
      expect_at(cyc + 1, 0, $sformatf("pre-reset beat%0d", i + 1), part[i], 0, 1, 1, 0, 0);
    end
    tick();
    vld = '0;
    tick();
    #2;
    rst_n = 1'b0;
    expect_at(cyc, 0, "async reset immediate", '0, 0, 0, 1, 0, 0);
    tick();
    rst_n = 1'b1;
    expect_at(cyc, 0, "async reset held", '0, 0, 0, 1, 0, 0);
    load4(0, 1'b0);

    // Reload with a simultaneous update while in RUN
    load4(1, 1'b1);
    tick();
    vld = '0; upd[1] = 1'b1; upd_tbc = 1'b1; tbc = 256'h5;
    expect_at(cyc + 1, 1, "reload dut run", 128'h5, 1, 0, 1, 0, 1);
    drive_beat(1, 128'h11111111);
    upd[1] = 1'b1; upd_tbc = 1'b1; tbc = 256'h77;
    expect_at(cyc + 1, 1, "reload beat wins", 128'h00000000_00000000_00000005_11111111,
              0, 1, 1, 1, 0);
    drive_beat(1, 128'h22222222);
    expect_at(cyc + 1, 1, "reload beat2", 128'h00000000_00000005_11111111_22222222,
              0, 1, 1, 1, 0);
    drive_beat(1, 128'h33333333);
    expect_at(cyc + 1, 1, "reload beat3", 128'h00000005_11111111_22222222_33333333,
              0, 1, 1, 1, 0);
    drive_beat(1, 128'h44444444);
    expect_at(cyc + 1, 1, "reload complete", 128'h11111111_22222222_33333333_44444444,
              1, 0, 1, 1, 0);

    // Wide bus, two shares; round counter wraps after 64 rounds
    drive_beat(2, 128'h0123456789ABCDEF_FEDCBA9876543210);
    expect_at(cyc + 1, 2, "wide beat1", {128'h0, 128'h0123456789ABCDEF_FEDCBA9876543210},
              0, 1, 1, 0, 0);
    drive_beat(2, FULL);
    expect_at(cyc + 1, 2, "wide beat2", {128'h0123456789ABCDEF_FEDCBA9876543210, FULL},
              1, 0, 0, 0, 0);
    for (int i = 1; i <= 64; i++) begin
      tick();
      vld = '0; upd[2] = 1'b1; upd_tbc = 1'b1; tbc = 256'(i);
      expect_at(cyc + 1, 2, $sformatf("wide tbc %0d", i), 256'(i), 1, 0, 0, 0, i % 64);
    end
    tick();
    upd = '0;

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: %0d checks pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
